// File: rtl/addsub_arbiter.sv
// addsub_arbiter
//   Round-robin arbiter and sequencer for the shared 8-bit adder_subtractor.
//   Two clients issue {a, b, op} requests. One request is granted at a time.
//   The winner's operands are registered onto alu_*. The adder result is
//   captured one cycle later with signed-overflow, zero and negative flags.
//   It is then returned on a valid/ready response channel, tagged with the
//   requester ID.
//
// Ports
//   clock, reset_n              clock, asynchronous active-low reset
//   reqN_valid/_a/_b/_op        request from client N (op: 0 = a+b, 1 = a-b)
//   reqN_ready                  grant; combinational, only asserted in IDLE
//   alu_a, alu_b, alu_op        registered operands to the shared adder
//   alu_result                  combinational result back from the adder
//   resp_valid, resp_ready      response handshake
//   resp_id                     requester that issued the operation
//   resp_result                 captured result (wraps mod 256)
//   resp_overflow/_zero/_negative  status flags of resp_result
module addsub_arbiter (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       req0_valid,
  input  logic [7:0] req0_a,
  input  logic [7:0] req0_b,
  input  logic       req0_op,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_a,
  input  logic [7:0] req1_b,
  input  logic       req1_op,
  output logic       req1_ready,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic       alu_op,
  input  logic [7:0] alu_result,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic [7:0] resp_result,
  output logic       resp_overflow,
  output logic       resp_zero,
  output logic       resp_negative
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic        last_grant_q;
  logic [7:0]  alu_a_q;
  logic [7:0]  alu_b_q;
  logic        alu_op_q;
  logic        resp_valid_q;
  logic        resp_id_q;
  logic [7:0]  resp_result_q;
  logic        resp_ovf_q;
  logic        resp_zero_q;
  logic        resp_neg_q;

  logic        grant0_d;
  logic        grant1_d;
  logic        win_id_d;
  logic [7:0]  win_a_d;
  logic [7:0]  win_b_d;
  logic        win_op_d;
  logic        ovf_d;

  // Two's complement overflow for a+b / a-b with wrapped result r.
  function automatic logic signed_ovf(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] r, input logic op);
    logic ovf;
    if (op) ovf = (a[7] != b[7]) && (r[7] != a[7]);
    else    ovf = (a[7] == b[7]) && (r[7] != a[7]);
    return ovf;
  endfunction

  // Grant decision. It is gated by reset_n so both readys read 0 while reset
  // is held, even though the state register already reads IDLE.
  // On a tie, the requester that did not win last time is served.
  always_comb begin
    grant0_d = 1'b0;
    grant1_d = 1'b0;
    if (reset_n && (state_q == IDLE)) begin
      if (req0_valid && (!req1_valid || last_grant_q)) grant0_d = 1'b1;
      else if (req1_valid)                             grant1_d = 1'b1;
    end
  end

  always_comb begin
    win_id_d = grant1_d;
    win_a_d  = grant1_d ? req1_a  : req0_a;
    win_b_d  = grant1_d ? req1_b  : req0_b;
    win_op_d = grant1_d ? req1_op : req0_op;
    ovf_d    = signed_ovf(alu_a_q, alu_b_q, alu_result, alu_op_q);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      alu_a_q       <= 8'd0;
      alu_b_q       <= 8'd0;
      alu_op_q      <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= 8'd0;
      resp_ovf_q    <= 1'b0;
      resp_zero_q   <= 1'b0;
      resp_neg_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant0_d || grant1_d) begin
            alu_a_q      <= win_a_d;
            alu_b_q      <= win_b_d;
            alu_op_q     <= win_op_d;
            resp_id_q    <= win_id_d;
            last_grant_q <= win_id_d;
            state_q      <= EXEC;
          end
        end
        // alu_* have been stable for a full cycle; sample the adder here only.
        EXEC: begin
          resp_result_q <= alu_result;
          resp_ovf_q    <= ovf_d;
          resp_zero_q   <= (alu_result == 8'd0);
          resp_neg_q    <= alu_result[7];
          resp_valid_q  <= 1'b1;
          state_q       <= RESP;
        end
        // Hold everything until the consumer takes the response.
        RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req0_ready    = grant0_d;
  assign req1_ready    = grant1_d;
  assign alu_a         = alu_a_q;
  assign alu_b         = alu_b_q;
  assign alu_op        = alu_op_q;
  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_result   = resp_result_q;
  assign resp_overflow = resp_ovf_q;
  assign resp_zero     = resp_zero_q;
  assign resp_negative = resp_neg_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Testbench for addsub_arbiter: table-driven vectors, hand-written corner
// sequences (reset mid-operation, round-robin, backpressure), random traffic,
// and a response scoreboard.
module tb_addsub_arbiter;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req0_valid, req0_op, req0_ready;
  logic [7:0] req0_a, req0_b;
  logic       req1_valid, req1_op, req1_ready;
  logic [7:0] req1_a, req1_b;
  logic [7:0] alu_a, alu_b, alu_result;
  logic       alu_op;
  logic       resp_valid, resp_ready, resp_id;
  logic [7:0] resp_result;
  logic       resp_overflow, resp_zero, resp_negative;

  int checks = 0;
  int errors = 0;
  string cur_tag = "init";

  logic [11:0] sb_q[$];
  logic [11:0] mon_exp;
  logic        lg_m;

  typedef struct {
    logic       v0;
    logic [7:0] a0, b0;
    logic       op0;
    logic       v1;
    logic [7:0] a1, b1;
    logic       op1;
    logic       exp_id;
    logic [7:0] exp_res;
    logic       exp_ovf, exp_zero, exp_neg;
  } vec_t;

  vec_t tbl[9];

  always #5 clock = ~clock;

  // Shared adder_subtractor behaviour.
  assign alu_result = alu_op ? (alu_a - alu_b) : (alu_a + alu_b);

  addsub_arbiter dut (
    .clock(clock), .reset_n(reset_n),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_ready(req1_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_result(resp_result), .resp_overflow(resp_overflow),
    .resp_zero(resp_zero), .resp_negative(resp_negative)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s actual=%0h required=%0h", cur_tag, name, act, exp);
    end
  endtask

  // Reference result via signed integer arithmetic: {id, result, ovf, zero, neg}.
  function automatic logic [11:0] ref_resp(input logic id, input logic [7:0] a,
                                           input logic [7:0] b, input logic op);
    int sa, sb, full;
    logic [7:0] r;
    sa   = int'($signed(a));
    sb   = int'($signed(b));
    full = op ? (sa - sb) : (sa + sb);
    r    = full[7:0];
    return {id, r, (full > 127) || (full < -128), (r == 8'd0), r[7]};
  endfunction

  // Scoreboard: pop one expectation per response handshake.
  always @(negedge clock) begin
    #2;
    if (reset_n && resp_valid && resp_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s/sb_unexpected actual=%0h required=none", cur_tag, resp_result);
      end else begin
        mon_exp = sb_q.pop_front();
        chk("sb_resp", 32'({resp_id, resp_result, resp_overflow, resp_zero, resp_negative}),
            32'(mon_exp));
      end
    end
  end

  task automatic clear_inputs();
    req0_valid = 1'b0; req0_a = 8'd0; req0_b = 8'd0; req0_op = 1'b0;
    req1_valid = 1'b0; req1_a = 8'd0; req1_b = 8'd0; req1_op = 1'b0;
    resp_ready = 1'b1;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    lg_m = 1'b1;
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic run_vec(input vec_t v);
    logic [7:0] ea, eb;
    logic       eop;
    req0_valid = v.v0; req0_a = v.a0; req0_b = v.b0; req0_op = v.op0;
    req1_valid = v.v1; req1_a = v.a1; req1_b = v.b1; req1_op = v.op1;
    resp_ready = 1'b1;
    #1;
    chk("rdy0", 32'(req0_ready), 32'(v.exp_id == 1'b0));
    chk("rdy1", 32'(req1_ready), 32'(v.exp_id == 1'b1));
    sb_q.push_back({v.exp_id, v.exp_res, v.exp_ovf, v.exp_zero, v.exp_neg});
    ea  = v.exp_id ? v.a1  : v.a0;
    eb  = v.exp_id ? v.b1  : v.b0;
    eop = v.exp_id ? v.op1 : v.op0;
    lg_m = v.exp_id;
    @(negedge clock);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #1;
    chk("alu_ops", 32'({alu_a, alu_b, alu_op}), 32'({ea, eb, eop}));
    chk("exec_vld", 32'(resp_valid), 32'd0);
    @(negedge clock);
    #1;
    chk("resp_vld", 32'(resp_valid), 32'd1);
    @(negedge clock);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [11:0] e;
    logic [7:0]  bp_a0, bp_b0, bp_a1, bp_b1;

    //            v0    a0      b0     op0   v1    a1      b1     op1   id    res     ovf   z     n
    tbl[0] = '{1'b1, 8'd100, 8'd27, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'd127, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h7F, 8'h01, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b1, 8'h80, 8'h01, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h7F, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h35, 8'h35, 1'b1, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{1'b1, 8'h0A, 8'h14, 1'b0, 1'b1, 8'h05, 8'h09, 1'b1, 1'b0, 8'h1E, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b1, 8'h01, 8'h01, 1'b0, 1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 8'h01, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b1};
    tbl[8] = '{1'b1, 8'hC8, 8'h64, 1'b1, 1'b1, 8'h02, 8'h03, 1'b0, 1'b0, 8'h64, 1'b1, 1'b0, 1'b0};

    // Reset state, with a request pending to show readys stay low.
    cur_tag = "reset";
    clear_inputs();
    reset_n = 1'b0;
    @(negedge clock);
    req0_valid = 1'b1;
    #1;
    chk("outs_in_reset", 32'({alu_a, alu_b, alu_op, resp_valid, resp_id, resp_result,
                              resp_overflow, resp_zero, resp_negative, req0_ready, req1_ready}), 32'd0);

    // Start a req0 op, then reset in the middle of EXEC.
    cur_tag = "reset_exec";
    @(negedge clock);
    reset_n = 1'b1;
    req0_valid = 1'b1; req0_a = 8'h11; req0_b = 8'h22; req0_op = 1'b0;
    @(negedge clock);
    req0_valid = 1'b0;
    #1;
    chk("alu_loaded", 32'({alu_a, alu_b}), 32'(16'h1122));
    #2;
    reset_n = 1'b0;
    #1;
    chk("outs_async_rst", 32'({alu_a, alu_b, alu_op, resp_valid, resp_id, resp_result,
                               resp_overflow, resp_zero, resp_negative, req0_ready, req1_ready}), 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    lg_m = 1'b1;
    #1;
    chk("no_resp_after_rst", 32'(resp_valid), 32'd0);
    @(negedge clock);
    #1;
    chk("still_no_resp", 32'(resp_valid), 32'd0);
    @(negedge clock);
    // Tie right after reset: req0 must win again because last_grant was reset.
    v = '{1'b1, 8'h03, 8'h04, 1'b0, 1'b1, 8'h09, 8'h09, 1'b1, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0};
    run_vec(v);

    // Table vectors.
    for (int i = 0; i < 9; i++) begin
      cur_tag = $sformatf("vec%0d", i);
      run_vec(tbl[i]);
    end

    // Round-robin: both valid continuously, grants every 3 cycles, 0,1,0,1.
    cur_tag = "rr";
    do_reset();
    req0_valid = 1'b1; req0_a = 8'd1;  req0_b = 8'd2; req0_op = 1'b0;
    req1_valid = 1'b1; req1_a = 8'd10; req1_b = 8'd3; req1_op = 1'b1;
    resp_ready = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      #1;
      chk($sformatf("rdy0_c%0d", cyc), 32'(req0_ready),
          32'((cyc % 3 == 0) && ((cyc / 3) % 2 == 0)));
      chk($sformatf("rdy1_c%0d", cyc), 32'(req1_ready),
          32'((cyc % 3 == 0) && ((cyc / 3) % 2 == 1)));
      if (cyc % 3 == 0) begin
        if ((cyc / 3) % 2 == 0) sb_q.push_back(ref_resp(1'b0, req0_a, req0_b, req0_op));
        else                    sb_q.push_back(ref_resp(1'b1, req1_a, req1_b, req1_op));
      end
      @(negedge clock);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lg_m = 1'b1;
    @(negedge clock);

    // Backpressure: response held for several cycles with both requesters waiting.
    cur_tag = "bp";
    bp_a0 = 8'h40; bp_b0 = 8'h40; bp_a1 = 8'h02; bp_b1 = 8'h05;
    req0_valid = 1'b1; req0_a = bp_a0; req0_b = bp_b0; req0_op = 1'b0;
    req1_valid = 1'b1; req1_a = bp_a1; req1_b = bp_b1; req1_op = 1'b1;
    resp_ready = 1'b0;
    #1;
    chk("rdy0_grant", 32'(req0_ready), 32'd1);
    chk("rdy1_grant", 32'(req1_ready), 32'd0);
    e = ref_resp(1'b0, bp_a0, bp_b0, 1'b0);
    sb_q.push_back(e);
    @(negedge clock);
    #1;
    chk("exec_rdys", 32'({req0_ready, req1_ready}), 32'd0);
    @(negedge clock);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("hold_rdys%0d", k), 32'({req0_ready, req1_ready}), 32'd0);
      chk($sformatf("hold_vld%0d", k), 32'(resp_valid), 32'd1);
      chk($sformatf("hold_resp%0d", k),
          32'({resp_id, resp_result, resp_overflow, resp_zero, resp_negative}), 32'(e));
      chk($sformatf("hold_alu%0d", k), 32'({alu_a, alu_b, alu_op}), 32'({bp_a0, bp_b0, 1'b0}));
      @(negedge clock);
    end
    resp_ready = 1'b1;
    #1;
    chk("vld_before_hs", 32'(resp_valid), 32'd1);
    @(negedge clock);
    #1;
    chk("next_grant_rdy1", 32'(req1_ready), 32'd1);
    chk("next_grant_rdy0", 32'(req0_ready), 32'd0);
    sb_q.push_back(ref_resp(1'b1, bp_a1, bp_b1, 1'b1));
    @(negedge clock);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(negedge clock);

    // Random traffic against the reference model.
    cur_tag = "rand";
    do_reset();
    for (int n = 0; n < 12; n++) begin
      cur_tag = $sformatf("rand%0d", n);
      v.v0 = 1'($urandom_range(0, 1));
      v.v1 = 1'($urandom_range(0, 1));
      if (!v.v0 && !v.v1) v.v0 = 1'b1;
      v.a0 = 8'($urandom); v.b0 = 8'($urandom); v.op0 = 1'($urandom_range(0, 1));
      v.a1 = 8'($urandom); v.b1 = 8'($urandom); v.op1 = 1'($urandom_range(0, 1));
      v.exp_id = (v.v0 && v.v1) ? ~lg_m : v.v1;
      e = v.exp_id ? ref_resp(1'b1, v.a1, v.b1, v.op1) : ref_resp(1'b0, v.a0, v.b0, v.op0);
      v.exp_res  = e[10:3];
      v.exp_ovf  = e[2];
      v.exp_zero = e[1];
      v.exp_neg  = e[0];
      run_vec(v);
    end

    cur_tag = "end";
    @(negedge clock);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
